// File: rtl/cv32e40p_ecc_pkg.sv
// Shared SECDED helpers: parity-width sizing, power-of-two position test, error class type.
// Used by the pipelined decoder and the syndrome core.
package cv32e40p_ecc_pkg;

    // Smallest r with 2^r >= data_width + r + 1.
    function automatic int ecc_par_width(input int data_width);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < data_width + r + 1) r = r + 1;
        end
        return r;
    endfunction

    function automatic logic is_pow2(input int position);
        return (position > 0) && ((position & (position - 1)) == 0);
    endfunction

    typedef struct packed {
        logic single_err;
        logic double_err;
    } ecc_status_t;

endpackage

// File: rtl/cv32e40p_secded_syndrome.sv
// Combinational SECDED core: Hamming syndrome, overall mismatch and corrected payload.
// Zero latency, no flow control; the flip is applied only for a correctable in-range syndrome.
module cv32e40p_secded_syndrome
    import cv32e40p_ecc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PAR_WIDTH  = ecc_par_width(DATA_WIDTH),
    parameter int CW_WIDTH   = DATA_WIDTH + PAR_WIDTH + 1
) (
    input  logic [CW_WIDTH-1:0]   codeword,
    output logic [PAR_WIDTH-1:0]  syndrome,
    output logic                  om,
    output logic [DATA_WIDTH-1:0] data_corr
);

    logic [CW_WIDTH-2:0] cw_fix;
    int                  k;

    always_comb begin
        syndrome = '0;
        for (int p = 1; p < CW_WIDTH; p++) begin
            if (codeword[p-1]) syndrome = syndrome ^ PAR_WIDTH'(p);
        end
        om = ^codeword;
    end

    // A syndrome beyond the last position never matches, so uncorrectable words pass through raw.
    always_comb begin
        cw_fix    = codeword[CW_WIDTH-2:0];
        data_corr = '0;
        k         = 0;
        for (int p = 1; p < CW_WIDTH; p++) begin
            if (om && (syndrome == PAR_WIDTH'(p))) cw_fix[p-1] = ~cw_fix[p-1];
        end
        for (int p = 1; p < CW_WIDTH; p++) begin
            if (!is_pow2(p)) begin
                data_corr[k] = cw_fix[p-1];
                k = k + 1;
            end
        end
    end

endmodule

// File: rtl/cv32e40p_secded_decoder_pipe.sv
// Pipelined SECDED decoder with error counters; 1-cycle latency.
// Single output register; in_ready_o = !out_valid_o | out_ready_i, results held while stalled.
module cv32e40p_secded_decoder_pipe
    import cv32e40p_ecc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PAR_WIDTH  = ecc_par_width(DATA_WIDTH),
    parameter int CW_WIDTH   = DATA_WIDTH + PAR_WIDTH + 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [CW_WIDTH-1:0]   data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [PAR_WIDTH-1:0]  syndrome_o,
    output logic                  err_single_o,
    output logic                  err_double_o,
    output logic [CNT_WIDTH-1:0]  corr_cnt_o,
    output logic [CNT_WIDTH-1:0]  uncorr_cnt_o,
    output logic                  fault_sticky_o,
    input  logic                  clr_i
);

    logic [PAR_WIDTH-1:0]  syn;
    logic                  om;
    logic [DATA_WIDTH-1:0] data_corr;
    ecc_status_t           status;
    logic                  accept;

    cv32e40p_secded_syndrome #(
        .DATA_WIDTH (DATA_WIDTH),
        .PAR_WIDTH  (PAR_WIDTH),
        .CW_WIDTH   (CW_WIDTH)
    ) u_syndrome (
        .codeword  (data_i),
        .syndrome  (syn),
        .om        (om),
        .data_corr (data_corr)
    );

    always_comb begin
        status = '0;
        if (om) begin
            if ((syn == '0) || (int'(syn) <= CW_WIDTH - 1)) status.single_err = 1'b1;
            else                                            status.double_err = 1'b1;
        end else if (syn != '0) begin
            status.double_err = 1'b1;
        end
    end

    assign in_ready_o = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_o  <= 1'b0;
            data_o       <= '0;
            syndrome_o   <= '0;
            err_single_o <= 1'b0;
            err_double_o <= 1'b0;
        end else if (accept) begin
            out_valid_o  <= 1'b1;
            data_o       <= data_corr;
            syndrome_o   <= syn;
            err_single_o <= status.single_err;
            err_double_o <= status.double_err;
        end else if (out_ready_i && out_valid_o) begin
            out_valid_o  <= 1'b0;
        end
    end

    // Clear has priority over a coincident erroneous word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt_o     <= '0;
            uncorr_cnt_o   <= '0;
            fault_sticky_o <= 1'b0;
        end else if (clr_i) begin
            corr_cnt_o     <= '0;
            uncorr_cnt_o   <= '0;
            fault_sticky_o <= 1'b0;
        end else if (accept) begin
            if (status.single_err && (corr_cnt_o != '1))
                corr_cnt_o <= corr_cnt_o + CNT_WIDTH'(1);
            if (status.double_err && (uncorr_cnt_o != '1))
                uncorr_cnt_o <= uncorr_cnt_o + CNT_WIDTH'(1);
            if (status.single_err || status.double_err)
                fault_sticky_o <= 1'b1;
        end
    end

endmodule
